// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester/bus signal bundle for bus_arbiter
//
// Signals:
//   req         requester -> arbiter   per-requester bus request (level)
//   wr_valid    requester -> arbiter   per-requester beat valid
//   wr_data     requester -> arbiter   per-requester data, slice i = [i*BUS_WIDTH +: BUS_WIDTH]
//   gnt         arbiter -> requester   one-hot grant
//   bus_data    arbiter -> bus         master_bus data
//   bus_valid   arbiter -> bus         master_bus beat strobe
//   bus_owner   arbiter -> bus         index of current/last owner
//   busy        arbiter -> bus         arbiter is in a tenure or turnaround
//   timeout_err arbiter -> bus         one-cycle watchdog revoke pulse
// Modports: master = requester side, slave = arbiter side.

interface bus_arbiter_if #(
    parameter int NUM_REQ   = 3,
    parameter int BUS_WIDTH = 24
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           wr_valid;
    logic [NUM_REQ*BUS_WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]           gnt;
    logic [BUS_WIDTH-1:0]         bus_data;
    logic                         bus_valid;
    logic [OW-1:0]                bus_owner;
    logic                         busy;
    logic                         timeout_err;

    modport master (
        output req, wr_valid, wr_data,
        input  gnt, bus_data, bus_valid, bus_owner, busy, timeout_err
    );

    modport slave (
        input  req, wr_valid, wr_data,
        output gnt, bus_data, bus_valid, bus_owner, busy, timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter and sequencer for the shared master_bus
//
// Ports:
//   clk   in  clock, all state on rising edge
//   rst   in  asynchronous active-low reset
//   bus   bus_arbiter_if.slave: req/wr_valid/wr_data in; gnt/bus_data/bus_valid/
//         bus_owner/busy/timeout_err out (all outputs registered except busy,
//         which decodes the state register)
// Optional feature: define BUS_ARB_TIMEOUT_EN to enable the idle-owner watchdog.
// Without it timeout_err is tied 0 and TIMEOUT_CYCLES has no effect.

module bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int BUS_WIDTH      = 24,
    parameter int MAX_BEATS      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = (MAX_BEATS < 2) ? 1 : $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [BUS_WIDTH-1:0] bus_data_q, bus_data_d;
    logic                 bus_valid_q, bus_valid_d;
    logic [CW-1:0]        beat_cnt_q, beat_cnt_d;

    logic                 found;
    logic [OW-1:0]        winner;
    logic                 beat;
    logic [CW:0]          beat_nxt;
    logic                 last_beat;
    logic                 revoke;

    // Rotating-priority scan starting at rr_ptr; rr_ptr is set past the
    // previous owner so that owner ends up with the lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [OW-1:0] idx;
            idx = OW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign beat      = (state_q == S_GRANT) && gnt_q[owner_q] && bus.wr_valid[owner_q];
    assign beat_nxt  = {1'b0, beat_cnt_q} + {{CW{1'b0}}, 1'b1};
    assign last_beat = (MAX_BEATS != 0) && beat && (beat_nxt == (CW+1)'(MAX_BEATS));

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          timeout_err_q;

    // A beat in the revoke cycle wins: the owner is making progress.
    assign revoke = (state_q == S_GRANT) && !beat && bus.req[owner_q]
                    && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q != S_GRANT || beat) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= revoke;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign revoke          = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        bus_data_d  = bus_data_q;
        bus_valid_d = 1'b0;
        beat_cnt_d  = beat_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_GRANT;
                    owner_d    = winner;
                    gnt_d      = NUM_REQ'(1) << winner;
                    beat_cnt_d = '0;
                end
            end
            S_GRANT: begin
                if (beat) begin
                    bus_valid_d = 1'b1;
                    bus_data_d  = bus.wr_data[owner_q*BUS_WIDTH +: BUS_WIDTH];
                    beat_cnt_d  = beat_nxt[CW-1:0];
                end
                // A beat coinciding with the req drop is still forwarded above.
                if (!bus.req[owner_q] || last_beat || revoke) begin
                    state_d = S_TURN;
                    gnt_d   = '0;
                end
            end
            S_TURN: begin
                state_d    = S_IDLE;
                gnt_d      = '0;
                beat_cnt_d = '0;
                rr_ptr_d   = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + OW'(1);
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            bus_data_q  <= bus_data_d;
            bus_valid_q <= bus_valid_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.bus_data  = bus_data_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_owner = owner_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter

module tb_bus_arbiter;
    localparam int NUM_REQ   = 3;
    localparam int BUS_WIDTH = 24;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    bus_arbiter_if #(.NUM_REQ(NUM_REQ), .BUS_WIDTH(BUS_WIDTH)) bif ();

    bus_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .BUS_WIDTH     (BUS_WIDTH),
        .MAX_BEATS     (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [23:0] val);
        bif.wr_data[idx*BUS_WIDTH +: BUS_WIDTH] = val;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst          = 1'b0;
        bif.req      = 3'b111;
        bif.wr_valid = 3'b000;
        bif.wr_data  = '0;

        // Reset held with all requests active
        tick();
        tick();
        check("rst_gnt",       32'(bif.gnt), 32'h0);
        check("rst_bus_valid", 32'(bif.bus_valid), 32'h0);
        check("rst_bus_data",  32'(bif.bus_data), 32'h0);
        check("rst_busy",      32'(bif.busy), 32'h0);
        check("rst_owner",     32'(bif.bus_owner), 32'h0);
        check("rst_tmo",       32'(bif.timeout_err), 32'h0);
        rst = 1'b1;
        tick();
        check("rst_first_gnt", 32'(bif.gnt), 32'h1);
        check("rst_first_busy", 32'(bif.busy), 32'h1);
        bif.req = 3'b000;
        tick();
        check("zero_turn_gnt",  32'(bif.gnt), 32'h0);
        check("zero_turn_busy", 32'(bif.busy), 32'h1);
        tick();
        check("zero_idle_busy", 32'(bif.busy), 32'h0);

        // Burst limit: requester 1 alone, six beats 1..6
        bif.req      = 3'b010;
        bif.wr_valid = 3'b010;
        set_data(1, 24'h000001);
        tick();
        check("bl_gnt",      32'(bif.gnt), 32'h2);
        check("bl_gnt_bv",   32'(bif.bus_valid), 32'h0);
        check("bl_owner",    32'(bif.bus_owner), 32'h1);
        for (int b = 1; b <= 4; b++) begin
            set_data(1, 24'(b));
            tick();
            check("bl_bv",   32'(bif.bus_valid), 32'h1);
            check("bl_data", 32'(bif.bus_data), 32'(b));
            check("bl_gnt_burst", 32'(bif.gnt), (b == 4) ? 32'h0 : 32'h2);
        end
        set_data(1, 24'h000005);
        tick();
        check("bl_turn_bv",  32'(bif.bus_valid), 32'h0);
        check("bl_turn_gnt", 32'(bif.gnt), 32'h0);
        check("bl_turn_data", 32'(bif.bus_data), 32'h4);
        tick();
        check("bl_regnt",    32'(bif.gnt), 32'h2);
        check("bl_regnt_bv", 32'(bif.bus_valid), 32'h0);
        tick();
        check("bl_b5_bv",    32'(bif.bus_valid), 32'h1);
        check("bl_b5_data",  32'(bif.bus_data), 32'h5);
        set_data(1, 24'h000006);
        tick();
        check("bl_b6_data",  32'(bif.bus_data), 32'h6);
        bif.req      = 3'b000;
        bif.wr_valid = 3'b000;
        tick();
        check("bl_end_gnt",  32'(bif.gnt), 32'h0);
        check("bl_end_bv",   32'(bif.bus_valid), 32'h0);
        tick();

        // Round robin: fresh reset, all requesters streaming
        rst = 1'b0;
        tick();
        rst          = 1'b1;
        bif.req      = 3'b111;
        bif.wr_valid = 3'b111;
        set_data(0, 24'h000A00);
        set_data(1, 24'h000B01);
        set_data(2, 24'h000C02);
        for (int t = 0; t < 4; t++) begin
            int o;
            logic [23:0] d;
            o = t % 3;
            d = (o == 0) ? 24'h000A00 : (o == 1) ? 24'h000B01 : 24'h000C02;
            tick();
            check("rr_gnt",   32'(bif.gnt), 32'(1 << o));
            check("rr_owner", 32'(bif.bus_owner), 32'(o));
            for (int b = 0; b < 4; b++) begin
                tick();
                check("rr_bv",   32'(bif.bus_valid), 32'h1);
                check("rr_data", 32'(bif.bus_data), 32'(d));
                check("rr_gnt_burst", 32'(bif.gnt), (b == 3) ? 32'h0 : 32'(1 << o));
            end
            tick();
            check("rr_gap_gnt", 32'(bif.gnt), 32'h0);
            check("rr_gap_bv",  32'(bif.bus_valid), 32'h0);
        end

        // Early release by owner 2 after two beats, requester 0 waiting
        bif.req      = 3'b100;
        bif.wr_valid = 3'b100;
        set_data(2, 24'hABCDEF);
        tick();
        check("er_gnt", 32'(bif.gnt), 32'h4);
        tick();
        check("er_b1_bv",   32'(bif.bus_valid), 32'h1);
        check("er_b1_data", 32'(bif.bus_data), 32'hABCDEF);
        set_data(2, 24'h123456);
        tick();
        check("er_b2_bv",   32'(bif.bus_valid), 32'h1);
        check("er_b2_data", 32'(bif.bus_data), 32'h123456);
        bif.req      = 3'b001;
        bif.wr_valid = 3'b000;
        tick();
        check("er_d1_gnt", 32'(bif.gnt), 32'h0);
        check("er_d1_bv",  32'(bif.bus_valid), 32'h0);
        tick();
        check("er_d2_gnt", 32'(bif.gnt), 32'h0);
        tick();
        check("er_d3_gnt", 32'(bif.gnt), 32'h1);
        check("er_d3_data", 32'(bif.bus_data), 32'h123456);

        // Ignored beats from a non-owner while owner 0 is silent
        bif.wr_valid = 3'b100;
        set_data(2, 24'hFFFFFF);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("ig_bv",   32'(bif.bus_valid), 32'h0);
            check("ig_data", 32'(bif.bus_data), 32'h123456);
            check("ig_gnt",  32'(bif.gnt), 32'h1);
            check("ig_tmo",  32'(bif.timeout_err), 32'h0);
        end

        // Req drop coinciding with a beat: beat forwarded, tenure ends
        bif.req      = 3'b000;
        bif.wr_valid = 3'b001;
        set_data(0, 24'h55AA55);
        tick();
        check("rd_bv",   32'(bif.bus_valid), 32'h1);
        check("rd_data", 32'(bif.bus_data), 32'h55AA55);
        check("rd_gnt",  32'(bif.gnt), 32'h0);
        bif.wr_valid = 3'b000;
        tick();
        tick();

        // Asynchronous reset in the middle of a tenure (rr_ptr now 1)
        bif.req      = 3'b010;
        bif.wr_valid = 3'b010;
        tick();
        check("ar_gnt", 32'(bif.gnt), 32'h2);
        tick();
        check("ar_bv_pre", 32'(bif.bus_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_gnt_async", 32'(bif.gnt), 32'h0);
        check("ar_bv_async",  32'(bif.bus_valid), 32'h0);
        check("ar_owner",     32'(bif.bus_owner), 32'h0);
        tick();
        rst          = 1'b1;
        bif.req      = 3'b000;
        bif.wr_valid = 3'b000;
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        // Watchdog: owner 0 holds req with no beats
        begin
            int n;
            bit seen;
            bif.req = 3'b001;
            tick();
            check("to_gnt", 32'(bif.gnt), 32'h1);
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 40) begin
                tick();
                n++;
                if (bif.timeout_err) seen = 1'b1;
            end
            check("to_cycles", 32'(n), 32'd16);
            check("to_gnt_off", 32'(bif.gnt), 32'h0);
            tick();
            check("to_pulse", 32'(bif.timeout_err), 32'h0);
            bif.req = 3'b000;
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
